prf_scoreboard: RTL
===================

# prf_scoreboard

Parametrised physical register file with an integrated per-register ready scoreboard, successor to the fixed 10-read/5-CDB PRF. It sits between rename/dispatch and the execution units. Rename allocations clear a register's ready bit, CDB writebacks set it and store data, and a flush restores all ready bits. Read ports return data plus readiness, with same-cycle CDB bypass and an optional registered read stage.

## Interface
- `P_REG_SIZE`, 128: number of physical registers; p0 is hardwired zero.
- `P_WIDTH`, `$clog2(P_REG_SIZE)`: physical address width.
- `DATA_W`, 32: register data width.
- `N_RD`, 10: number of read ports.
- `N_WR`, 5: number of write (CDB) ports.
- `N_ALLOC`, 1: number of rename allocation ports.
- `READ_LATENCY`, 0: 0 = combinational read, 1 = registered read; other values are illegal and trigger an elaboration `$error`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `wr_valid`  in  [N_WR]  CDB write enable per port.
- `wr_paddr`  in  [N_WR][P_WIDTH]  write destination.
- `wr_data`  in  [N_WR][DATA_W]  write value.
- `alloc_valid`  in  [N_ALLOC]  rename allocated a new destination.
- `alloc_paddr`  in  [N_ALLOC][P_WIDTH]  allocated register.
- `flush`  in  1  mispredict/exception recovery.
- `rd_paddr`  in  [N_RD][P_WIDTH]  read address.
- `rd_data`  out  [N_RD][DATA_W]  read value.
- `rd_ready`  out  [N_RD]  operand-available flag.

## Operation
- Storage: `data[P_REG_SIZE]` and `ready[P_REG_SIZE]`.
- Reset:
  - All `data` entries are 0 and all `ready` bits are 1.
  - With `READ_LATENCY`=1, `rd_data` resets to 0 and `rd_ready` resets to 1.
- Write:
  - For each port i with `wr_valid[i]` and `wr_paddr[i]`≠0: `data[paddr]<=wr_data[i]` and `ready[paddr]<=1`.
  - Writes to p0 are ignored.
  - Two ports writing the same paddr in one cycle: the highest-index port wins. This is illegal usage; the implementation flags it with an assertion but the hardware behaviour is as stated.
- Alloc:
  - For each `alloc_valid[j]` with `alloc_paddr[j]`≠0: `ready[paddr]<=0`. Data is unchanged.
  - Alloc of p0 is ignored.
- Same cycle, same paddr, alloc and write: data is written and the ready bit ends at 0 (the new producer wins).
- Flush:
  - Every `ready` bit becomes 1 next cycle.
  - Flush overrides any same-cycle alloc.
  - Same-cycle writes still update data.
- Read value, computed the same way for every port k:
  - `rd_paddr`=0 gives data 0, ready 1.
  - Otherwise the value starts as `data[rd_paddr]` / `ready[rd_paddr]`.
  - Any same-cycle valid write matching the address overrides it with `wr_data` and ready=1. The highest matching index wins, consistent with the write rule.
  - Same-cycle alloc and flush do not affect the read result.
- `READ_LATENCY`=0: `rd_data`/`rd_ready` are combinational from the current `rd_paddr` and current writes.
- `READ_LATENCY`=1: the combinational result is registered and presented the next cycle. Writes arriving in that next cycle are not reflected; consumers snoop the CDB themselves.

## Timing
- Write latency: a write in cycle t is visible through bypass in t and from storage in t+1.
- Alloc in cycle t: `ready` reads 0 from t+1. A read in cycle t still sees the old ready bit.
- Flush in cycle t: all ready from t+1.
- Reset asserted mid-operation: at the next edge, state is as at reset. Inputs in that cycle are ignored.
- Read path for `READ_LATENCY`=0: no added flops.
- Read path for `READ_LATENCY`=1: exactly one flop stage; there is no stall or enable.
- Throughput: all ports are independent, every cycle, with no back-pressure.

## Test plan
- **Reset:** assert `rst` 1 cycle → every port reads data 0, ready 1. Write p5=0xDEAD during `rst` → p5 still reads 0 after.
- **Alloc, bypass, write:**
  - Alloc p12 at t → at t+1 `rd_ready`=0 for p12.
  - At t+3, `wr_valid[2]` p12=0x1234 → same cycle, with `READ_LATENCY`=0, reads 0x1234/ready 1.
  - At t+4 storage holds 0x1234.
- **Collisions:**
  - Ports 1 and 4 both write p7 (0x1111 / 0x4444) → bypass and storage show 0x4444.
  - Alloc and write p9 in the same cycle → p9 data is the written value, ready=0.
- **p0:** write p0=0xFFFF and alloc p0 → p0 always reads 0, ready 1.
- **Flush:**
  - Alloc p20..p23, then `flush` together with alloc p30 → next cycle p20..p23 and p30 are all ready.
  - Data written during the flush cycle persists.
- **READ_LATENCY=1:**
  - Address p40 at t with a same-cycle write of 0xABCD → output 0xABCD/ready 1 at t+1, not at t.
  - Change the address at t+1 → the output updates at t+2.

Source files
------------

// File: rtl/prf_scoreboard.sv
// Physical register file with per-register ready scoreboard, CDB bypass on
// every read port and an optional registered read stage.

module prf_rd_port #(
  parameter int P_WIDTH = 7,
  parameter int DATA_W  = 32,
  parameter int N_WR    = 5
) (
  input  logic [P_WIDTH-1:0]           rd_paddr,
  input  logic [DATA_W-1:0]            stor_data,
  input  logic                         stor_ready,
  input  logic [N_WR-1:0]              wr_valid,
  input  logic [N_WR-1:0][P_WIDTH-1:0] wr_paddr,
  input  logic [N_WR-1:0][DATA_W-1:0]  wr_data,
  output logic [DATA_W-1:0]            byp_data,
  output logic                         byp_ready
);

  // Ascending scan so the highest-index matching CDB port wins, same as storage.
  always_comb begin
    byp_data  = stor_data;
    byp_ready = stor_ready;
    for (int i = 0; i < N_WR; i++) begin
      if (wr_valid[i] && (wr_paddr[i] == rd_paddr)) begin
        byp_data  = wr_data[i];
        byp_ready = 1'b1;
      end
    end
    if (rd_paddr == '0) begin
      byp_data  = '0;
      byp_ready = 1'b1;
    end
  end

endmodule

module prf_scoreboard #(
  parameter int P_REG_SIZE   = 128,
  parameter int P_WIDTH      = $clog2(P_REG_SIZE),
  parameter int DATA_W       = 32,
  parameter int N_RD         = 10,
  parameter int N_WR         = 5,
  parameter int N_ALLOC      = 1,
  parameter int READ_LATENCY = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_WR-1:0]                 wr_valid,
  input  logic [N_WR-1:0][P_WIDTH-1:0]    wr_paddr,
  input  logic [N_WR-1:0][DATA_W-1:0]     wr_data,
  input  logic [N_ALLOC-1:0]              alloc_valid,
  input  logic [N_ALLOC-1:0][P_WIDTH-1:0] alloc_paddr,
  input  logic                            flush,
  input  logic [N_RD-1:0][P_WIDTH-1:0]    rd_paddr,
  output logic [N_RD-1:0][DATA_W-1:0]     rd_data,
  output logic [N_RD-1:0]                 rd_ready
);

  if ((READ_LATENCY != 0) && (READ_LATENCY != 1)) begin : g_bad_latency
    $error("prf_scoreboard: READ_LATENCY must be 0 or 1");
  end

  logic [P_REG_SIZE-1:0][DATA_W-1:0] data_q, data_d;
  logic [P_REG_SIZE-1:0]             ready_q, ready_d;
  logic [N_RD-1:0][DATA_W-1:0]       byp_data;
  logic [N_RD-1:0]                   byp_ready;
  logic                              wr_collide;

  // Writes set ready first, then allocs clear it (new producer wins), then
  // flush forces everything ready; p0 is pinned to zero/ready last.
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    for (int i = 0; i < N_WR; i++) begin
      if (wr_valid[i]) begin
        data_d[wr_paddr[i]]  = wr_data[i];
        ready_d[wr_paddr[i]] = 1'b1;
      end
    end
    for (int j = 0; j < N_ALLOC; j++) begin
      if (alloc_valid[j]) ready_d[alloc_paddr[j]] = 1'b0;
    end
    if (flush) ready_d = '1;
    data_d[0]  = '0;
    ready_d[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      ready_q <= '1;
    end else begin
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    wr_collide = 1'b0;
    for (int i = 0; i < N_WR; i++) begin
      for (int j = i + 1; j < N_WR; j++) begin
        if (wr_valid[i] && wr_valid[j] && (wr_paddr[i] == wr_paddr[j]) &&
            (wr_paddr[i] != '0))
          wr_collide = 1'b1;
      end
    end
  end

  // Illegal usage is reported but the hardware still resolves it deterministically.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!wr_collide)
        else $warning("prf_scoreboard: two CDB ports wrote the same paddr");
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    prf_rd_port #(
      .P_WIDTH (P_WIDTH),
      .DATA_W  (DATA_W),
      .N_WR    (N_WR)
    ) u_rd (
      .rd_paddr   (rd_paddr[k]),
      .stor_data  (data_q[rd_paddr[k]]),
      .stor_ready (ready_q[rd_paddr[k]]),
      .wr_valid   (wr_valid),
      .wr_paddr   (wr_paddr),
      .wr_data    (wr_data),
      .byp_data   (byp_data[k]),
      .byp_ready  (byp_ready[k])
    );
  end

  if (READ_LATENCY == 1) begin : g_rd_reg
    logic [N_RD-1:0][DATA_W-1:0] rd_data_q, rd_data_d;
    logic [N_RD-1:0]             rd_ready_q, rd_ready_d;

    always_comb begin
      rd_data_d  = byp_data;
      rd_ready_d = byp_ready;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_ready_q <= '1;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_ready_q <= rd_ready_d;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_ready = rd_ready_q;
  end else begin : g_rd_comb
    assign rd_data  = byp_data;
    assign rd_ready = byp_ready;
  end

endmodule
